m_axi4l_wr_channel: RTL and testbench
=====================================

// Module: m_axi4l_wr_channel
// PURPOSE
//  AXI4-Lite master write channel: turns a single-beat register-write request from local logic
//  into AW and W transactions, waits for B, returns the write response to the requester.
//  Drives the s_axi4l_wr_channel slave end; one write outstanding at a time.
// PARAMETERS
//  AXI_DATA_WIDTH  32                   data bus width, multiple of 8
//  AXI_ADDR_WIDTH  4                    address width
//  AXI_STRB_WIDTH  AXI_DATA_WIDTH/8     byte strobe width
// PORTS
//  i_axi_clock         in   1     clock; all logic on rising edge
//  i_axi_reset         in   1     synchronous, active-high reset
//  i_req_addr          in   ADDR  write address
//  i_req_prot          in   3     AWPROT for this write
//  i_req_data          in   DATA  write data
//  i_req_strb          in   STRB  byte strobes
//  i_req_valid         in   1     request valid
//  o_req_ready         out  1     request accepted when valid & ready
//  o_rsp_resp          out  2     captured BRESP
//  o_rsp_valid         out  1     response valid
//  i_rsp_ready         in   1     response consumed when valid & ready
//  o_axi_awaddr        out  ADDR  AW address
//  o_axi_awprot        out  3     AW protection
//  o_axi_awaddr_valid  out  1     AWVALID
//  i_axi_awaddr_ready  in   1     AWREADY
//  o_axi_wdata         out  DATA  W data
//  o_axi_wstrb         out  STRB  W strobes
//  o_axi_wdata_valid   out  1     WVALID
//  i_axi_wdata_ready   in   1     WREADY
//  i_axi_bresp         in   2     BRESP
//  i_axi_bvalid        in   1     BVALID
//  o_axi_bready        out  1     BREADY
// BEHAVIOUR
//  - States: IDLE, SEND, WAIT_B, RESP. Reset (sync, i_axi_reset=1) -> IDLE; all AXI/rsp outputs and
//    payload registers 0; o_req_ready=0 while i_axi_reset=1.
//  - IDLE: o_req_ready=1. On i_req_valid: register addr/prot/data/strb, set aw_pend=w_pend=1, -> SEND.
//    Accept at edge N -> o_axi_awaddr_valid and o_axi_wdata_valid both 1 from cycle N+1 (registered).
//  - SEND: o_req_ready=0. AWVALID=aw_pend, WVALID=w_pend; asserted independent of ready, never withdrawn
//    before handshake. Payload outputs constant while their valid is 1. aw_pend clears on
//    AWVALID&AWREADY, w_pend on WVALID&WREADY, each independently; either order or same cycle.
//    Cycle in which last pending handshake completes -> WAIT_B (both valids 0 next cycle).
//  - WAIT_B: o_axi_bready=1 (0 in every other state). On i_axi_bvalid: capture i_axi_bresp into
//    o_rsp_resp, -> RESP. BVALID outside WAIT_B is ignored.
//  - RESP: o_rsp_valid=1, o_rsp_resp stable; on i_rsp_ready -> IDLE. o_rsp_resp holds last value in IDLE.
//  - Min turnaround with always-ready slave and B one cycle after W: request-accept to rsp_valid = 3
//    cycles; next request accepted 4 cycles after previous accept. No request accepted outside IDLE.
//  - i_req_* changes while not in IDLE have no effect on AXI outputs.
//  - Reset mid-transaction: at next edge state=IDLE, all valids/bready 0, transaction abandoned,
//    no response produced.
//  - BRESP passed through unmodified (OKAY 00, SLVERR 10, DECERR 11).
// TESTING
//  1 Req addr=0x4 data=0xDEADBEEF strb=0xF, slave always ready, BVALID one cycle after W hs ->
//    AW/W valid exactly cycle N+1, bready cycle N+2, rsp_valid resp=00 cycle N+3.
//  2 AWREADY low 3 cycles, WREADY high -> WVALID 1 cycle; AWVALID 4 cycles, awaddr stable;
//    bready only after AW hs.
//  3 WREADY low 3 cycles, AWREADY high, strb=0x5 -> mirror of 2; wdata/wstrb=0x5 stable until W hs.
//  4 BVALID after 5 cycles with bresp=10, i_rsp_ready low 3 cycles -> o_rsp_resp=10, rsp_valid held
//    4 cycles, o_req_ready=0 until return to IDLE.
//  5 i_req_valid held high with changing data during SEND/WAIT_B -> single transaction with first
//    payload; second request accepted only once back in IDLE.
//  6 i_axi_reset pulsed in SEND and in WAIT_B -> next cycle all valids, bready, rsp_valid 0; new write
//    afterwards completes normally.

Source files
------------

// File: rtl/m_axi4l_wr_channel.sv
// AXI4-Lite master write channel: one register write per request, AW/W issued
// together, B collected and returned on the rsp port. One write in flight at a time.
module m_axi4l_wr_channel #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 4,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_reset,
  input  logic [AXI_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2:0]                i_req_prot,
  input  logic [AXI_DATA_WIDTH-1:0] i_req_data,
  input  logic [AXI_STRB_WIDTH-1:0] i_req_strb,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  output logic [1:0]                o_rsp_resp,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]                o_axi_awprot,
  output logic                      o_axi_awaddr_valid,
  input  logic                      i_axi_awaddr_ready,
  output logic [AXI_DATA_WIDTH-1:0] o_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] o_axi_wstrb,
  output logic                      o_axi_wdata_valid,
  input  logic                      i_axi_wdata_ready,
  input  logic [1:0]                i_axi_bresp,
  input  logic                      i_axi_bvalid,
  output logic                      o_axi_bready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      aw_pend_q, aw_pend_d;
  logic                      w_pend_q, w_pend_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                prot_q, prot_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [AXI_STRB_WIDTH-1:0] strb_q, strb_d;
  logic [1:0]                resp_q, resp_d;
  logic                      req_ready_q, req_ready_d;
  logic                      bready_q, bready_d;
  logic                      rsp_valid_q, rsp_valid_d;

  // Next-state and next-output logic; handshake-facing flags are derived from state_d
  // so every output comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    data_d    = data_q;
    strb_d    = strb_q;
    resp_d    = resp_q;

    unique case (state_q)
      IDLE: begin
        if (i_req_valid && req_ready_q) begin
          addr_d    = i_req_addr;
          prot_d    = i_req_prot;
          data_d    = i_req_data;
          strb_d    = i_req_strb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        // AW and W complete independently, in either order or together.
        if (aw_pend_q && i_axi_awaddr_ready) aw_pend_d = 1'b0;
        if (w_pend_q && i_axi_wdata_ready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)          state_d   = WAIT_B;
      end
      WAIT_B: begin
        if (i_axi_bvalid) begin
          resp_d  = i_axi_bresp;
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    bready_d    = (state_d == WAIT_B);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset abandons any write in flight.
  always_ff @(posedge i_axi_clock) begin
    if (i_axi_reset) begin
      state_q     <= IDLE;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      addr_q      <= '0;
      prot_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      resp_q      <= '0;
      req_ready_q <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      resp_q      <= resp_d;
      req_ready_q <= req_ready_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_req_ready        = req_ready_q;
  assign o_rsp_resp         = resp_q;
  assign o_rsp_valid        = rsp_valid_q;
  assign o_axi_awaddr       = addr_q;
  assign o_axi_awprot       = prot_q;
  assign o_axi_awaddr_valid = aw_pend_q;
  assign o_axi_wdata        = data_q;
  assign o_axi_wstrb        = strb_q;
  assign o_axi_wdata_valid  = w_pend_q;
  assign o_axi_bready       = bready_q;

endmodule

// File: tb/tb_m_axi4l_wr_channel.sv
// Directed bench for m_axi4l_wr_channel: the bench plays requester and AXI slave,
// sampling outputs 1 ns after each rising edge.
module tb_m_axi4l_wr_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_addr;
  logic [2:0]  req_prot;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  rsp_resp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  m_axi4l_wr_channel #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(4)
  ) dut (
    .i_axi_clock       (clk),
    .i_axi_reset       (rst),
    .i_req_addr        (req_addr),
    .i_req_prot        (req_prot),
    .i_req_data        (req_data),
    .i_req_strb        (req_strb),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .o_rsp_resp        (rsp_resp),
    .o_rsp_valid       (rsp_valid),
    .i_rsp_ready       (rsp_ready),
    .o_axi_awaddr      (awaddr),
    .o_axi_awprot      (awprot),
    .o_axi_awaddr_valid(awvalid),
    .i_axi_awaddr_ready(awready),
    .o_axi_wdata       (wdata),
    .o_axi_wstrb       (wstrb),
    .o_axi_wdata_valid (wvalid),
    .i_axi_wdata_ready (wready),
    .i_axi_bresp       (bresp),
    .i_axi_bvalid      (bvalid),
    .o_axi_bready      (bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Control outputs in one go: {awvalid, wvalid, bready, rsp_valid, req_ready}.
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, 32'({awvalid, wvalid, bready, rsp_valid, req_ready}), 32'(exp));
  endtask

  task automatic set_req(input logic [3:0] a, input logic [2:0] p,
                         input logic [31:0] d, input logic [3:0] s);
    req_addr = a;
    req_prot = p;
    req_data = d;
    req_strb = s;
  endtask

  // Entered in a WAIT_B cycle: return B one cycle later, then consume the response.
  task automatic finish_b(input string tag, input logic [1:0] r);
    chk_ctl({tag, "_waitb"}, 5'b00100);
    bvalid = 1'b1;
    bresp  = r;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    chk_ctl({tag, "_resp"}, 5'b00010);
    chk({tag, "_bresp"}, 32'(rsp_resp), 32'(r));
    rsp_ready = 1'b1;
    tick();
    chk_ctl({tag, "_idle"}, 5'b00001);
    chk({tag, "_resp_hold"}, 32'(rsp_resp), 32'(r));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    set_req(4'h0, 3'h0, 32'h0, 4'h0);
    rsp_ready = 1'b1;
    awready   = 1'b1;
    wready    = 1'b1;
    bvalid    = 1'b0;
    bresp     = 2'b00;

    // Reset state
    tick();
    tick();
    chk_ctl("rst_ctl", 5'b00000);
    chk("rst_awaddr", 32'(awaddr), 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_resp", 32'(rsp_resp), 32'h0);
    rst = 1'b0;
    tick();
    chk_ctl("post_rst_idle", 5'b00001);

    // 1: minimum-latency write
    set_req(4'h4, 3'h2, 32'hDEADBEEF, 4'hF);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_ctl("t1_send", 5'b11000);
    chk("t1_awaddr", 32'(awaddr), 32'h4);
    chk("t1_awprot", 32'(awprot), 32'h2);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_wstrb", 32'(wstrb), 32'hF);
    tick();
    finish_b("t1", 2'b00);

    // 2: AWREADY low for three cycles
    awready = 1'b0;
    set_req(4'h8, 3'h0, 32'h11223344, 4'hF);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_ctl("t2_c1", 5'b11000);
    tick();
    chk_ctl("t2_c2", 5'b10000);
    chk("t2_awaddr_c2", 32'(awaddr), 32'h8);
    tick();
    chk_ctl("t2_c3", 5'b10000);
    tick();
    chk_ctl("t2_c4", 5'b10000);
    chk("t2_awaddr_c4", 32'(awaddr), 32'h8);
    awready = 1'b1;
    tick();
    finish_b("t2", 2'b00);

    // 3: WREADY low for three cycles
    wready = 1'b0;
    set_req(4'hC, 3'h1, 32'hA5A50F0F, 4'h5);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_ctl("t3_c1", 5'b11000);
    tick();
    chk_ctl("t3_c2", 5'b01000);
    chk("t3_wdata_c2", wdata, 32'hA5A50F0F);
    tick();
    chk_ctl("t3_c3", 5'b01000);
    tick();
    chk_ctl("t3_c4", 5'b01000);
    chk("t3_wdata_c4", wdata, 32'hA5A50F0F);
    chk("t3_wstrb_c4", 32'(wstrb), 32'h5);
    wready = 1'b1;
    tick();
    finish_b("t3", 2'b00);

    // 4: slow BVALID with SLVERR, requester stalls the response
    set_req(4'h0, 3'h0, 32'h0BADF00D, 4'hF);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_ctl("t4_waitb", 5'b00100);
      tick();
    end
    chk_ctl("t4_waitb_last", 5'b00100);
    bvalid = 1'b1;
    bresp  = 2'b10;
    rsp_ready = 1'b0;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("t4_resp_hold", 5'b00010);
      chk("t4_resp_val", 32'(rsp_resp), 32'h2);
      tick();
    end
    chk_ctl("t4_resp_last", 5'b00010);
    rsp_ready = 1'b1;
    tick();
    chk_ctl("t4_idle", 5'b00001);
    chk("t4_resp_kept", 32'(rsp_resp), 32'h2);

    // 5: req_valid held with changing payload; only the first is taken
    awready = 1'b0;
    set_req(4'hC, 3'h3, 32'hCAFEF00D, 4'hF);
    req_valid = 1'b1;
    tick();
    set_req(4'h1, 3'h0, 32'h12345678, 4'h1);
    chk_ctl("t5_send", 5'b11000);
    tick();
    set_req(4'h2, 3'h0, 32'h9ABCDEF0, 4'h2);
    chk("t5_awaddr", 32'(awaddr), 32'hC);
    chk("t5_awprot", 32'(awprot), 32'h3);
    awready = 1'b1;
    tick();
    set_req(4'h6, 3'h5, 32'h55AA33CC, 4'h9);
    chk("t5_wdata_kept", wdata, 32'hCAFEF00D);
    rsp_ready = 1'b0;
    finish_b("t5", 2'b11);
    chk("t5_resp_decerr", 32'(rsp_resp), 32'h3);
    tick();
    chk_ctl("t5_second_send", 5'b11000);
    chk("t5_second_addr", 32'(awaddr), 32'h6);
    chk("t5_second_data", wdata, 32'h55AA33CC);
    req_valid = 1'b0;
    tick();
    finish_b("t5b", 2'b00);

    // 6: reset during SEND, then during WAIT_B with BVALID left high
    awready = 1'b0;
    wready  = 1'b0;
    set_req(4'h4, 3'h0, 32'hFEEDFACE, 4'hF);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_ctl("t6_send", 5'b11000);
    rst = 1'b1;
    tick();
    chk_ctl("t6_rst_send", 5'b00000);
    rst = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    chk_ctl("t6_idle_a", 5'b00001);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk_ctl("t6_waitb", 5'b00100);
    rst    = 1'b1;
    bvalid = 1'b1;
    bresp  = 2'b10;
    tick();
    chk_ctl("t6_rst_waitb", 5'b00000);
    chk("t6_rst_resp", 32'(rsp_resp), 32'h0);
    rst = 1'b0;
    tick();
    chk_ctl("t6_bvalid_ignored", 5'b00001);
    bvalid = 1'b0;
    bresp  = 2'b00;
    set_req(4'h8, 3'h4, 32'h13579BDF, 4'hC);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk_ctl("t6_new_send", 5'b11000);
    chk("t6_new_data", wdata, 32'h13579BDF);
    tick();
    finish_b("t6", 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
